// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch FSM with PC sequencing and optional fetch timeout (FETCH_TIMEOUT_EN).
module instr_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        sel_pc,
    input  logic        sel_addpc,
    output logic        fetch_err
);
    typedef enum logic [1:0] {START, FETCH, HOLD, ERROR} state_t;
    state_t state;
    logic [31:0] pc4, jmp_tgt, br_tgt, next_pc;
    assign pc4       = pc + 32'd4;
    assign jmp_tgt   = {pc4[31:28], instr[25:0], 2'b00};
    assign br_tgt    = pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign next_pc   = sel_pc ? jmp_tgt : sel_addpc ? br_tgt : pc4;
    assign imem_addr = pc;
    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];
`ifdef FETCH_TIMEOUT_EN
    logic [7:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= START;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fetch_err   <= 1'b0;
            cnt         <= '0;
        end else begin
            unique case (state)
                START: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    cnt      <= '0;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end else if (cnt + 8'd1 == TIMEOUT_CYCLES) begin
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                        state     <= ERROR;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (exec_done) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        cnt         <= '0;
                        state       <= FETCH;
                    end
                end
                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    fetch_err   <= 1'b1;
                end
            endcase
        end
    end
`else
    assign fetch_err = 1'b0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= START;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
        end else begin
            unique case (state)
                START: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (exec_done) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of fetch/PC sequencing; two instances differ only in RESET_PC.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        exec_done = 1'b0;
    logic        sel_pc = 1'b0;
    logic        sel_addpc = 1'b0;
    logic        imem_req, instr_valid, fetch_err;
    logic [31:0] imem_addr, pc, instr;
    logic [5:0]  opcode, funct;
    logic        h_req, h_valid, h_err;
    logic [31:0] h_addr, h_pc, h_instr;
    logic [5:0]  h_opcode, h_funct;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(8'd4)) u_dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .instr(instr),
        .opcode(opcode), .funct(funct), .instr_valid(instr_valid),
        .exec_done(exec_done), .sel_pc(sel_pc), .sel_addpc(sel_addpc), .fetch_err(fetch_err)
    );

    instr_fetch #(.RESET_PC(32'h4000_0000), .TIMEOUT_CYCLES(8'd4)) u_hi (
        .clk(clk), .rst(rst), .imem_req(h_req), .imem_addr(h_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(h_pc), .instr(h_instr),
        .opcode(h_opcode), .funct(h_funct), .instr_valid(h_valid),
        .exec_done(exec_done), .sel_pc(sel_pc), .sel_addpc(sel_addpc), .fetch_err(h_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expects a FETCH cycle; holds off the ack for dly cycles, checking the address stays put.
    task automatic fetch(input logic [31:0] rdata, input int dly, input logic [31:0] addr);
        check("fetch_req", {31'b0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, addr);
        for (int i = 0; i < dly; i++) begin
            step();
            check("wait_req", {31'b0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, addr);
        end
        imem_ack = 1'b1;
        imem_rdata = rdata;
        step();
        imem_ack = 1'b0;
        check("hold_valid", {31'b0, instr_valid}, 32'd1);
        check("hold_req", {31'b0, imem_req}, 32'd0);
        check("hold_instr", instr, rdata);
    endtask

    task automatic exec(input logic sp, input logic sa, input logic [31:0] exp_pc);
        exec_done = 1'b1;
        sel_pc = sp;
        sel_addpc = sa;
        step();
        exec_done = 1'b0;
        sel_pc = 1'b0;
        sel_addpc = 1'b0;
        check("next_pc", pc, exp_pc);
        check("next_valid", {31'b0, instr_valid}, 32'd0);
        check("next_req", {31'b0, imem_req}, 32'd1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        step();
        check("rst_req2", {31'b0, imem_req}, 32'd1);
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        check("reset_pc", pc, 32'h0);
        check("reset_req", {31'b0, imem_req}, 32'd0);
        check("reset_valid", {31'b0, instr_valid}, 32'd0);
        check("reset_instr", instr, 32'h0);
        check("reset_err", {31'b0, fetch_err}, 32'd0);
        step();
        fetch(32'h0000_0820, 0, 32'h0);
        check("opcode", {26'b0, opcode}, 32'h00);
        check("funct", {26'b0, funct}, 32'h20);
        exec(1'b0, 1'b0, 32'h0000_0004);
        fetch(32'h0800_0004, 0, 32'h0000_0004);
        exec(1'b1, 1'b0, 32'h0000_0010);
        fetch(32'h1000_FFFF, 0, 32'h0000_0010);
        check("br_opcode", {26'b0, opcode}, 32'h04);
        exec(1'b0, 1'b1, 32'h0000_0010);
        fetch(32'h1000_0002, 0, 32'h0000_0010);
        exec(1'b0, 1'b0, 32'h0000_0014);
        fetch(32'h1000_FFFE, 3, 32'h0000_0014);
        exec(1'b0, 1'b1, 32'h0000_0010);
        fetch(32'h1000_0002, 0, 32'h0000_0010);
        exec(1'b0, 1'b1, 32'h0000_001C);
        // exec_done while still fetching must not move the PC
        exec_done = 1'b1;
        sel_pc = 1'b1;
        step();
        exec_done = 1'b0;
        sel_pc = 1'b0;
        check("fetch_exec_pc", pc, 32'h0000_001C);
        check("fetch_exec_req", {31'b0, imem_req}, 32'd1);
        fetch(32'h1000_FFF7, 0, 32'h0000_001C);
        pulse_rst();
        fetch(32'h1000_FFFE, 0, 32'h0);
        exec(1'b0, 1'b1, 32'hFFFF_FFFC);
        fetch(32'h1234_5678, 0, 32'hFFFF_FFFC);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        check("late_ack_instr", instr, 32'h1234_5678);
        check("late_ack_valid", {31'b0, instr_valid}, 32'd1);
        exec(1'b0, 1'b0, 32'h0000_0000);
        fetch(32'h0800_0004, 0, 32'h0);
        exec(1'b1, 1'b0, 32'h0000_0010);
        pulse_rst();
        check("hi_addr", h_addr, 32'h4000_0000);
        fetch(32'h0800_0100, 0, 32'h0);
        exec(1'b1, 1'b1, 32'h0000_0400);
        check("hi_jump_pc", h_pc, 32'h4000_0400);
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 3; i++) step();
        check("to_err_early", {31'b0, fetch_err}, 32'd0);
        check("to_req_early", {31'b0, imem_req}, 32'd1);
        step();
        check("to_err", {31'b0, fetch_err}, 32'd1);
        check("to_req", {31'b0, imem_req}, 32'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        step();
        imem_ack = 1'b0;
        check("to_late_valid", {31'b0, instr_valid}, 32'd0);
        check("to_late_err", {31'b0, fetch_err}, 32'd1);
        check("to_late_instr", instr, 32'h0800_0100);
`else
        for (int i = 0; i < 20; i++) step();
        check("no_to_err", {31'b0, fetch_err}, 32'd0);
        check("no_to_req", {31'b0, imem_req}, 32'd1);
        check("no_to_addr", imem_addr, 32'h0000_0400);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
